period_meter: RTL

- Measures an incoming divided/slow clock or square wave in units of the system clock. It recovers the period and high time, in clk cycles, of a signal such as a divider output.
- Used for self-check of on-board clock dividers and for measuring external square-wave inputs.
- Supports single-shot measurement (start pulse) and continuous back-to-back measurement.
- Reports a timeout when no edge arrives in time.

---
 rtl/period_meter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/period_meter.sv
// Measures period and high time of a slow square wave in clk cycles.
// Single-shot or back-to-back operation, with a timeout when no edge arrives.
module period_meter #(
  parameter int          WIDTH   = 32,
  parameter int unsigned TIMEOUT = 200_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic             valid,
  output logic             timeout,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE
  } state_t;

  localparam logic [WIDTH-1:0] LP_CNT_LAST = WIDTH'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] LP_ONE      = WIDTH'(1);

  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_high_cnt;
  logic             r_busy;
  logic             r_valid;
  logic             r_timeout;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_high_time;

  logic             w_rise;
  logic             w_fall;
  logic             w_cnt_last;
  logic [WIDTH-1:0] w_cnt_inc;

  // NOTE: synchronizer flops carry no reset; they only ever hold sampled pin
  // data, and the reset hold time flushes them before the FSM looks at them.
  always_ff @(posedge clk) begin
    r_s1 <= sig_in;
    r_s2 <= r_s1;
    r_s3 <= r_s2;
  end

  assign w_rise     = r_s2 & ~r_s3;
  assign w_fall     = ~r_s2 & r_s3;
  assign w_cnt_last = (r_cnt == LP_CNT_LAST);
  assign w_cnt_inc  = r_cnt + LP_ONE;

  // NOTE: all state updates use non-blocking assignments so every register
  // sees the pre-edge value of every other register, matching real flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_high_cnt  <= '0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_timeout   <= 1'b0;
      r_period    <= '0;
      r_high_time <= '0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_ARM;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end

        ST_ARM: begin
          if (w_rise) begin
            r_state <= ST_MEASURE;
            r_cnt   <= '0;
          end else if (w_cnt_last) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_valid     <= 1'b1;
            r_timeout   <= 1'b1;
            r_period    <= '0;
            r_high_time <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        ST_MEASURE: begin
          r_cnt <= w_cnt_inc;
          if (w_fall) begin
            r_high_cnt <= w_cnt_inc;
          end
          // A rise on the last counted cycle still completes the measurement.
          if (w_rise) begin
            r_period    <= w_cnt_inc;
            r_high_time <= r_high_cnt;
            r_valid     <= 1'b1;
            r_timeout   <= 1'b0;
            if (cont) begin
              r_cnt <= '0;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (w_cnt_last) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_valid     <= 1'b1;
            r_timeout   <= 1'b1;
            r_period    <= '0;
            r_high_time <= '0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign valid     = r_valid;
  assign timeout   = r_timeout;
  assign period    = r_period;
  assign high_time = r_high_time;

endmodule
